msram_banked: RTL and testbench
===============================

// Module: msram_banked
// PURPOSE
//  - Parametrised N-bank single-port SRAM array for FFT data storage. Successor to the fixed 4x1024x64 bank wrapper.
//  - Adds per-bank enable/write-enable, a read-valid flag and a post-reset hardware clear sequencer.
//  - Sits between the FFT address generators and the butterfly datapath. Each bank is one butterfly lane.
// PARAMETERS
//  - NUM_BANKS  4     number of independent banks
//  - DATA_W     64    word width (complex: 32b re | 32b im)
//  - DEPTH      1024  words per bank; power of 2, >=2
//  - ADDR_W     $clog2(DEPTH)  derived; not overridable
// PORTS
//  - CLK   in   1               clock; all logic on posedge
//  - RST   in   1               synchronous, active-high reset
//  - EN    in   NUM_BANKS       per-bank access enable
//  - WE    in   NUM_BANKS       per-bank write enable; valid only when the matching EN bit is 1
//  - ADDR  in   NUM_BANKS*ADDR_W  packed addresses; bank b at [b*ADDR_W +: ADDR_W]
//  - D     in   NUM_BANKS*DATA_W  packed write data; bank b at [b*DATA_W +: DATA_W]
//  - Q     out  NUM_BANKS*DATA_W  packed read data; held between reads
//  - QV    out  NUM_BANKS       read-data valid; 1-cycle pulse per completed read
//  - BUSY  out  1               clear sequence in progress; requests ignored
// BEHAVIOUR
//  - Reset: one clock with RST=1 gives Q=0, QV=0, BUSY=1, clear counter=0, FSM=CLEAR.
//    Memory contents are not reset directly; they are zeroed by the CLEAR state.
//  - FSM states: CLEAR, READY.
//    - CLEAR: each cycle with RST=0, every bank writes 0 at the counter address, then the counter increments.
//    - On the cycle writing DEPTH-1: FSM->READY and BUSY falls at that edge.
//    - Total: DEPTH cycles of BUSY after RST deasserts.
//  - RST asserted mid-CLEAR restarts the counter at 0. No wrap or overrun is possible.
//  - During CLEAR: EN/WE/ADDR/D are ignored, QV stays 0, Q holds 0.
//  - READY, per bank b, independently:
//    - EN=1, WE=1: MEM[ADDR] <= D. Q and QV unchanged (QV=0 next cycle).
//    - EN=1, WE=0: Q <= MEM[ADDR] at the edge; QV=1 for the following cycle (latency 1).
//    - EN=0: no access; Q holds, QV=0.
//    - Write has precedence; a bank does not read and write in the same cycle (single port).
//  - A read of an address written on the previous cycle returns the new data.
//  - Back-to-back reads give one word per cycle; QV stays high continuously.
//  - WE with EN=0 is a no-op. Address is always in range; no bounds check is needed.
// CONFIGURATION
//  - MSRAM_OUTREG_EN defined:
//    - adds one output register stage per bank (Q and QV both delayed); read latency becomes 2.
//    - RST clears the extra stage to Q=0, QV=0.
//    - During CLEAR the extra stage still shifts zeros/0.
//  - MSRAM_OUTREG_EN undefined: read latency is 1, as above.
// STRUCTURE
//  - Package msram_pkg:
//    - typedef enum logic {ST_CLEAR, ST_READY} msram_state_t
//    - localparam defaults MSRAM_DATA_W=64, MSRAM_DEPTH=1024
//  - Sub-module msram_bank: one bank with EN, WE, ADDR, D, Q, QV and clear-write override inputs.
//    Instantiated NUM_BANKS times in a generate loop.
//  - The top level holds only the shared FSM, the clear counter and BUSY.
// TESTING
//  1. RST high 2 cycles, then low -> BUSY=1 for exactly DEPTH cycles, then 0. Reads of all addresses return 0.
//  2. Bank 0: write addr 5 = 64'hDEAD_BEEF_0123_4567, next cycle read addr 5
//     -> Q[63:0]=that value with QV[0]=1 one cycle after the read (two with MSRAM_OUTREG_EN).
//  3. All 4 banks: same cycle, different addrs 0/1/2/3, data 'h11/'h22/'h33/'h44; then read them all
//     -> each bank returns its own data and QV=4'b1111 in the same cycle.
//  4. Read bank 2 addr 7, then EN=0 for 3 cycles -> Q held at the addr-7 data, QV[2]=0 after the first cycle.
//  5. EN=1, WE=1 issued while BUSY=1 (addr 3, 'hFF) -> ignored; after BUSY falls, a read of addr 3 returns 0.
//  6. RST pulsed when the clear counter = DEPTH/2 -> BUSY stays 1 for a full DEPTH cycles after the
//     deassert; no QV pulses during that time.

Source files
------------

// File: rtl/msram_pkg.sv
// Shared types and defaults for the banked FFT SRAM (msram_banked, msram_bank).
// Optional build macro MSRAM_OUTREG_EN is consumed by msram_bank.
package msram_pkg;

   typedef enum logic {ST_CLEAR, ST_READY} msram_state_t;

   localparam int MSRAM_NUM_BANKS = 4;
   localparam int MSRAM_DATA_W    = 64;
   localparam int MSRAM_DEPTH     = 1024;

   // Observation point for the shared sequencer: current state and clear-write strobe.
   typedef struct packed {
      msram_state_t state;
      logic         clr_we;
   } msram_dbg_t;

endpackage

// File: rtl/msram_bank.sv
// One single-port bank: user access when idle, zero-write override while clearing.
// MSRAM_OUTREG_EN adds a second output register stage (read latency 2).
module msram_bank
   import msram_pkg::*;
#(
   parameter  int DATA_W = MSRAM_DATA_W,
   parameter  int DEPTH  = MSRAM_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              WE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] D,
   input  logic              CLR,
   input  logic              CLR_WE,
   input  logic [ADDR_W-1:0] CLR_ADDR,
   output logic [DATA_W-1:0] Q,
   output logic              QV
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              acc_wr;
   logic              acc_rd;
   logic [DATA_W-1:0] q1;
   logic              qv1;

   // Requests are dropped entirely while the clear sequence owns the array.
   assign acc_wr = EN & WE & ~CLR;
   assign acc_rd = EN & ~WE & ~CLR;

   always_ff @(posedge CLK) begin
      if (CLR_WE) begin
         mem[CLR_ADDR] <= '0;
      end else if (acc_wr) begin
         mem[ADDR] <= D;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q1  <= '0;
         qv1 <= 1'b0;
      end else begin
         qv1 <= acc_rd;
         if (acc_rd) begin
            q1 <= mem[ADDR];
         end
      end
   end

`ifdef MSRAM_OUTREG_EN
   logic [DATA_W-1:0] q2;
   logic              qv2;

   always_ff @(posedge CLK) begin
      if (RST) begin
         q2  <= '0;
         qv2 <= 1'b0;
      end else begin
         q2  <= q1;
         qv2 <= qv1;
      end
   end

   assign Q  = q2;
   assign QV = qv2;
`else
   assign Q  = q1;
   assign QV = qv1;
`endif

endmodule

// File: rtl/msram_banked.sv
// N-bank single-port SRAM for FFT lanes with a post-reset hardware clear sequencer.
// Build option MSRAM_OUTREG_EN (in msram_bank) adds an output register stage.
module msram_banked
   import msram_pkg::*;
#(
   parameter  int NUM_BANKS = MSRAM_NUM_BANKS,
   parameter  int DATA_W    = MSRAM_DATA_W,
   parameter  int DEPTH     = MSRAM_DEPTH,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_BANKS-1:0]          EN,
   input  logic [NUM_BANKS-1:0]          WE,
   input  logic [NUM_BANKS*ADDR_W-1:0]   ADDR,
   input  logic [NUM_BANKS*DATA_W-1:0]   D,
   output logic [NUM_BANKS*DATA_W-1:0]   Q,
   output logic [NUM_BANKS-1:0]          QV,
   output logic                          BUSY
);

   msram_state_t      state;
   msram_state_t      state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_last;
   msram_dbg_t        dbg;

   assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (dbg.clr_we) begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (clr_last) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      dbg        = '0;
      dbg.state  = state;
      dbg.clr_we = (state == ST_CLEAR) & ~RST;
   end

   assign BUSY = (dbg.state == ST_CLEAR);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      msram_bank #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_bank (
         .CLK      (CLK),
         .RST      (RST),
         .EN       (EN[b]),
         .WE       (WE[b]),
         .ADDR     (ADDR[b*ADDR_W +: ADDR_W]),
         .D        (D[b*DATA_W +: DATA_W]),
         .CLR      (BUSY),
         .CLR_WE   (dbg.clr_we),
         .CLR_ADDR (clr_cnt),
         .Q        (Q[b*DATA_W +: DATA_W]),
         .QV       (QV[b])
      );
   end

endmodule

// File: tb/tb_msram_banked.sv
// Bench for msram_banked: hand table, clear/reset sequences and random traffic vs a memory model.
// Honours MSRAM_OUTREG_EN for the expected read latency.
module tb_msram_banked;

   localparam int NB    = 4;
   localparam int DW    = 64;
   localparam int DEPTH = 64;
   localparam int AW    = $clog2(DEPTH);
   localparam int W     = NB*DW + NB;
`ifdef MSRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic [NB-1:0]       EN = '0;
   logic [NB-1:0]       WE = '0;
   logic [NB*AW-1:0]    ADDR = '0;
   logic [NB*DW-1:0]    D = '0;
   logic [NB*DW-1:0]    Q;
   logic [NB-1:0]       QV;
   logic                BUSY;

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   msram_banked #(.NUM_BANKS(NB), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .D(D),
      .Q(Q), .QV(QV), .BUSY(BUSY)
   );

   // ---------------- scoreboard / model ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] ref_mem [NB][DEPTH];
   logic [DW-1:0] ref_q [NB];

   typedef struct {
      string            name;
      logic [NB-1:0]    en;
      logic [NB-1:0]    we;
      logic [NB*AW-1:0] addr;
      logic [NB*DW-1:0] d;
      logic [NB*DW-1:0] exp_d;
      logic [NB-1:0]    exp_v;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [NB*DW-1:0] pack_ref();
      logic [NB*DW-1:0] r;
      for (int b = 0; b < NB; b++) r[b*DW +: DW] = ref_q[b];
      return r;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         ref_q[b] = '0;
         for (int a = 0; a < DEPTH; a++) ref_mem[b][a] = '0;
      end
      exp_q.delete();
   endtask

   // Outputs visible before the first modelled access (output stage contents).
   task automatic prefill();
      for (int i = 0; i < LAT-1; i++) exp_q.push_back({pack_ref(), NB'(0)});
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [NB-1:0] en, input logic [NB-1:0] we,
                       input logic [NB*AW-1:0] addr, input logic [NB*DW-1:0] d);
      logic [NB-1:0] v;
      int a;
      EN = en; WE = we; ADDR = addr; D = d;
      v = '0;
      for (int b = 0; b < NB; b++) begin
         a = int'(addr[b*AW +: AW]);
         if (en[b] && !we[b]) begin
            ref_q[b] = ref_mem[b][a];
            v[b] = 1'b1;
         end else if (en[b] && we[b]) begin
            ref_mem[b][a] = d[b*DW +: DW];
         end
      end
      exp_q.push_back({pack_ref(), v});
      @(posedge CLK); #1;
      check("step", {Q, QV}, exp_q.pop_front());
   endtask

   task automatic idle();
      step('0, '0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      RST = 1'b1; EN = '0; WE = '0;
      repeat (n) @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
      check("reset_q_qv", {Q, QV}, '0);
      check("reset_busy", W'(BUSY), W'(1));
   endtask

   // Runs while BUSY, optionally hammering the ports; flags any QV/Q activity.
   task automatic busy_run(input int max_edges, input bit poke, output int edges, inout bit bad);
      edges = 0;
      while (BUSY && edges < max_edges) begin
         for (int b = 0; b < NB; b++) begin
            ADDR[b*AW +: AW] = poke ? AW'(3) : AW'($urandom_range(0, DEPTH-1));
            D[b*DW +: DW]    = poke ? DW'(64'hFF) : {$urandom, $urandom};
         end
         EN = poke ? '1 : NB'($urandom);
         WE = poke ? '1 : NB'($urandom);
         @(posedge CLK); #1;
         edges++;
         if (QV != '0 || Q != '0) bad = 1'b1;
      end
      EN = '0; WE = '0;
   endtask

   initial begin
      int e;
      bit bad;
      logic [NB*AW-1:0] ra;
      logic [NB*DW-1:0] rd;

      // ---- power-up clear ----
      bad = 1'b0;
      do_reset(2);
      busy_run(4*DEPTH, 1'b0, e, bad);
      check("busy_len", W'(e), W'(DEPTH));
      check("clear_quiet", W'(bad), '0);
      check("busy_low", W'(BUSY), '0);
      prefill();
      for (int a = 0; a < DEPTH; a++) begin
         for (int b = 0; b < NB; b++) ra[b*AW +: AW] = AW'(a);
         step('1, '0, ra, '0);
      end
      for (int i = 0; i < LAT-1; i++) idle();

      // ---- hand-computed table ----
      for (int i = 0; i < 6; i++) begin
         tbl[i].en = '0; tbl[i].we = '0; tbl[i].addr = '0; tbl[i].d = '0;
         tbl[i].exp_d = '0; tbl[i].exp_v = '0;
      end
      tbl[0].name = "wr_b0_a5"; tbl[0].en = 4'b0001; tbl[0].we = 4'b0001;
      tbl[0].addr[0 +: AW] = AW'(5); tbl[0].d[0 +: DW] = 64'hDEAD_BEEF_0123_4567;
      tbl[1].name = "rd_b0_a5"; tbl[1].en = 4'b0001;
      tbl[1].addr[0 +: AW] = AW'(5);
      tbl[1].exp_d[0 +: DW] = 64'hDEAD_BEEF_0123_4567; tbl[1].exp_v = 4'b0001;
      tbl[2].name = "wr_all"; tbl[2].en = 4'b1111; tbl[2].we = 4'b1111;
      tbl[2].exp_d[0 +: DW] = 64'hDEAD_BEEF_0123_4567;
      tbl[3].name = "rd_all"; tbl[3].en = 4'b1111; tbl[3].exp_v = 4'b1111;
      for (int b = 0; b < NB; b++) begin
         tbl[2].addr[b*AW +: AW] = AW'(b);
         tbl[2].d[b*DW +: DW]    = DW'(8'h11 * (b+1));
         tbl[3].addr[b*AW +: AW] = AW'(b);
         tbl[3].exp_d[b*DW +: DW] = DW'(8'h11 * (b+1));
      end
      tbl[4].name = "wr_b2_a7"; tbl[4].en = 4'b0100; tbl[4].we = 4'b0100;
      tbl[4].addr[2*AW +: AW] = AW'(7); tbl[4].d[2*DW +: DW] = 64'h7777;
      tbl[4].exp_d = tbl[3].exp_d;
      tbl[5].name = "rd_b2_a7"; tbl[5].en = 4'b0100;
      tbl[5].addr[2*AW +: AW] = AW'(7);
      tbl[5].exp_d = tbl[3].exp_d; tbl[5].exp_d[2*DW +: DW] = 64'h7777;
      tbl[5].exp_v = 4'b0100;

      for (int i = 0; i < 6; i++) begin
         step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].d);
         for (int j = 0; j < LAT-1; j++) idle();
         check(tbl[i].name, {Q, QV}, {tbl[i].exp_d, tbl[i].exp_v});
      end
      repeat (3) idle();
      check("hold_q_b2", W'(Q[2*DW +: DW]), W'(64'h7777));
      check("hold_qv", W'(QV), '0);

      // ---- writes while BUSY are ignored ----
      bad = 1'b0;
      do_reset(1);
      busy_run(4*DEPTH, 1'b1, e, bad);
      check("busy_len_poke", W'(e), W'(DEPTH));
      check("poke_quiet", W'(bad), '0);
      prefill();
      for (int b = 0; b < NB; b++) ra[b*AW +: AW] = AW'(3);
      step('1, '0, ra, '0);
      for (int j = 0; j < LAT-1; j++) idle();
      check("rd_a3_zero", {Q, QV}, {{(NB*DW){1'b0}}, 4'b1111});

      // ---- reset pulse mid-clear restarts the count ----
      bad = 1'b0;
      do_reset(1);
      busy_run(DEPTH/2, 1'b0, e, bad);
      check("mid_busy", W'(BUSY), W'(1));
      do_reset(1);
      busy_run(4*DEPTH, 1'b0, e, bad);
      check("busy_len_restart", W'(e), W'(DEPTH));
      check("restart_quiet", W'(bad), '0);
      prefill();

      // ---- random traffic against the model ----
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < NB; b++) begin
            ra[b*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1))
                                                         : AW'($urandom_range(0, 7));
            rd[b*DW +: DW] = {$urandom, $urandom};
         end
         step(NB'($urandom), NB'($urandom), ra, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
